// File: rtl/brightness_contrast_adj.sv
// brightness_contrast_adj: 3-stage stallable brightness/contrast stage, 4 px/clk RGB888 AXI-Stream.
// Define BRIGHTNESS_CONTRAST_RUNTIME_CFG_EN for runtime C/B ports latched at frame start.
module brightness_contrast_adj #(
  parameter logic        [8:0] CONTRAST_VAL = 9'd128,
  parameter logic signed [8:0] BRIGHT_VAL   = 9'sd0
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic [95:0]       I_tdata,
  input  logic              I_tvalid,
  output logic              I_tready,
  input  logic              I_tuser,
  input  logic              I_tlast,
  output logic [95:0]       O_tdata,
  output logic              O_tvalid,
  input  logic              O_tready,
  output logic              O_tuser,
  output logic              O_tlast
`ifdef BRIGHTNESS_CONTRAST_RUNTIME_CFG_EN
  ,
  input  logic [8:0]        I_cfg_contrast,
  input  logic signed [8:0] I_cfg_bright
`endif
);

  localparam int LANES = 12;

  logic en;
  logic accept;

  assign en       = O_tready | ~O_tvalid;
  assign I_tready = en;
  assign accept   = I_tvalid & en;

  logic [8:0]        c_in;
  logic signed [8:0] b_in;

`ifdef BRIGHTNESS_CONTRAST_RUNTIME_CFG_EN
  logic [8:0]        c_eff;
  logic signed [8:0] b_eff;

  // the frame-start beat itself already sees the new settings
  always_comb begin
    c_in = c_eff;
    b_in = b_eff;
    if (accept && I_tuser) begin
      c_in = I_cfg_contrast;
      b_in = I_cfg_bright;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      c_eff <= CONTRAST_VAL;
      b_eff <= BRIGHT_VAL;
    end else if (accept && I_tuser) begin
      c_eff <= I_cfg_contrast;
      b_eff <= I_cfg_bright;
    end
  end
`else
  assign c_in = CONTRAST_VAL;
  assign b_in = BRIGHT_VAL;
`endif

  logic signed [8:0] d_nxt [LANES];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      d_nxt[i] = $signed({1'b0, I_tdata[8*i +: 8]}) - 9'sd128;
    end
  end

  logic              s1_valid;
  logic              s1_user;
  logic              s1_last;
  logic signed [8:0] s1_d [LANES];
  logic [8:0]        s1_c;
  logic signed [8:0] s1_b;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      s1_valid <= 1'b0;
      s1_user  <= 1'b0;
      s1_last  <= 1'b0;
      s1_c     <= CONTRAST_VAL;
      s1_b     <= BRIGHT_VAL;
      for (int i = 0; i < LANES; i++) s1_d[i] <= '0;
    end else if (en) begin
      s1_valid <= accept;
      s1_user  <= I_tuser;
      s1_last  <= I_tlast;
      s1_c     <= c_in;
      s1_b     <= b_in;
      for (int i = 0; i < LANES; i++) s1_d[i] <= d_nxt[i];
    end
  end

  // gain is unsigned, so it gets a zero sign bit before the signed multiply
  logic signed [17:0] mul_w [LANES];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      mul_w[i] = $signed({{9{s1_d[i][8]}}, s1_d[i]}) * $signed({9'd0, s1_c});
    end
  end

  logic               s2_valid;
  logic               s2_user;
  logic               s2_last;
  logic signed [17:0] s2_p [LANES];
  logic signed [8:0]  s2_b;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      s2_valid <= 1'b0;
      s2_user  <= 1'b0;
      s2_last  <= 1'b0;
      s2_b     <= BRIGHT_VAL;
      for (int i = 0; i < LANES; i++) s2_p[i] <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_user  <= s1_user;
      s2_last  <= s1_last;
      s2_b     <= s1_b;
      for (int i = 0; i < LANES; i++) s2_p[i] <= mul_w[i];
    end
  end

  // arithmetic shift gives floor division by 128, then re-centre, offset, clamp
  logic signed [17:0] sum_w [LANES];
  logic [95:0]        out_nxt;

  always_comb begin
    out_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_w[i] = (s2_p[i] >>> 7) + 18'sd128 + $signed({{9{s2_b[8]}}, s2_b});
      if (sum_w[i][17]) begin
        out_nxt[8*i +: 8] = 8'h00;
      end else if (sum_w[i] > 18'sd255) begin
        out_nxt[8*i +: 8] = 8'hFF;
      end else begin
        out_nxt[8*i +: 8] = sum_w[i][7:0];
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_tvalid <= 1'b0;
      O_tuser  <= 1'b0;
      O_tlast  <= 1'b0;
      O_tdata  <= '0;
    end else if (en) begin
      O_tvalid <= s2_valid;
      O_tuser  <= s2_user;
      O_tlast  <= s2_last;
      O_tdata  <= out_nxt;
    end
  end

endmodule

// File: tb/tb_brightness_contrast_adj.sv
// tb_brightness_contrast_adj: several parameterised instances share one stimulus stream;
// every output beat is compared with an arithmetic reference model.
`timescale 1ns/1ps
module tb_brightness_contrast_adj;

  localparam int NCFG = 6;
  localparam logic [8:0]        C_TAB [NCFG] = '{9'd128, 9'd511, 9'd64, 9'd128, 9'd128, 9'd0};
  localparam logic signed [8:0] B_TAB [NCFG] = '{9'sh000, 9'sh000, 9'sh000, 9'sh100, 9'sh0FF, 9'sh1E4};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [95:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tuser = 1'b0;
  logic        tlast = 1'b0;
  logic        o_ready = 1'b1;

  logic        i_tready [NCFG];
  logic [95:0] o_tdata  [NCFG];
  logic        o_tvalid [NCFG];
  logic        o_tuser  [NCFG];
  logic        o_tlast  [NCFG];

`ifdef BRIGHTNESS_CONTRAST_RUNTIME_CFG_EN
  logic [8:0]        cfg_c [NCFG];
  logic signed [8:0] cfg_b [NCFG];
  initial for (int g = 0; g < NCFG; g++) begin
    cfg_c[g] = C_TAB[g];
    cfg_b[g] = B_TAB[g];
  end
`endif

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    brightness_contrast_adj #(.CONTRAST_VAL(C_TAB[g]), .BRIGHT_VAL(B_TAB[g])) dut (
      .I_clk    (clk),
      .I_rst_n  (rst_n),
      .I_tdata  (tdata),
      .I_tvalid (tvalid),
      .I_tready (i_tready[g]),
      .I_tuser  (tuser),
      .I_tlast  (tlast),
      .O_tdata  (o_tdata[g]),
      .O_tvalid (o_tvalid[g]),
      .O_tready (o_ready),
      .O_tuser  (o_tuser[g]),
      .O_tlast  (o_tlast[g])
`ifdef BRIGHTNESS_CONTRAST_RUNTIME_CFG_EN
      ,
      .I_cfg_contrast (cfg_c[g]),
      .I_cfg_bright   (cfg_b[g])
`endif
    );
  end

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input logic [95:0] act, input logic [95:0] exp, input string nm);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for the DUT", nm);
  endtask

  // out = clamp(floor((x-128)*C/128) + 128 + B, 0, 255)
  function automatic logic [7:0] ref_px(input int x, input int c, input int b);
    int t, q, s;
    t = (x - 128) * c;
    q = (t >= 0) ? t / 128 : -((-t + 127) / 128);
    s = q + 128 + b;
    if (s < 0) return 8'd0;
    if (s > 255) return 8'd255;
    return 8'(s);
  endfunction

  function automatic logic [95:0] ref_beat(input logic [95:0] d, input int c, input int b);
    logic [95:0] r;
    r = '0;
    for (int i = 0; i < 12; i++) r[8*i +: 8] = ref_px(int'(d[8*i +: 8]), c, b);
    return r;
  endfunction

  typedef struct {
    logic [95:0] d;
    logic        u;
    logic        l;
    int          cyc;
    int          c0;
    int          b0;
  } beat_t;

  beat_t sb[$];
  int    eff_c0 = int'(C_TAB[0]);
  int    eff_b0 = int'(B_TAB[0]);

  // backpressure generator: 0 = always ready, 1 = random, 2 = one 5-cycle stall window
  int bp_mode = 0;
  int tcyc = 0;
  int stall_from = 0;

  always @(posedge clk) begin
    #1;
    tcyc++;
    case (bp_mode)
      0:       o_ready = 1'b1;
      1:       o_ready = ($urandom_range(0, 3) != 0);
      default: o_ready = !(tcyc >= stall_from && tcyc < stall_from + 5);
    endcase
  end

  int          cyc = 0;
  int          last_stall = -1;
  int          tready_low = 0;
  bit          prev_hold = 0;
  logic [95:0] prev_data;
  logic [1:0]  prev_ul;

  always @(negedge clk) begin
    if (rst_n) begin
      beat_t e;
      cyc++;
      chk({95'd0, i_tready[0]}, {95'd0, (o_ready | ~o_tvalid[0])}, "tready_rule");
      if (!i_tready[0]) begin
        last_stall = cyc;
        tready_low++;
      end
      if (prev_hold) begin
        chk({95'd0, o_tvalid[0]}, 96'd1, "hold_valid");
        chk(o_tdata[0], prev_data, "hold_data");
        chk({94'd0, o_tuser[0], o_tlast[0]}, {94'd0, prev_ul}, "hold_user_last");
      end
      prev_hold = o_tvalid[0] && !o_ready;
      prev_data = o_tdata[0];
      prev_ul   = {o_tuser[0], o_tlast[0]};
      if (o_tvalid[0] && o_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got %h expected no beat", o_tdata[0]);
        end else begin
          e = sb.pop_front();
          for (int g = 0; g < NCFG; g++) begin
            chk(o_tdata[g],
                ref_beat(e.d, (g == 0) ? e.c0 : int'(C_TAB[g]), (g == 0) ? e.b0 : int'(B_TAB[g])),
                $sformatf("data_cfg%0d", g));
          end
          chk({94'd0, o_tuser[0], o_tlast[0]}, {94'd0, e.u, e.l}, "user_last");
          if (last_stall < e.cyc) chk(96'(cyc - e.cyc), 96'd3, "latency");
        end
      end
      if (tvalid && i_tready[0]) begin
`ifdef BRIGHTNESS_CONTRAST_RUNTIME_CFG_EN
        if (tuser) begin
          eff_c0 = int'(cfg_c[0]);
          eff_b0 = int'(cfg_b[0]);
        end
`endif
        e.d = tdata; e.u = tuser; e.l = tlast; e.cyc = cyc; e.c0 = eff_c0; e.b0 = eff_b0;
        sb.push_back(e);
      end
    end else begin
      prev_hold = 0;
    end
  end

  task automatic send(input logic [95:0] d, input logic u, input logic l);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = i_tready[0];
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) fail_timeout("send");
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    tvalid = 1'b0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) fail_timeout("drain");
    idle(2);
  endtask

  task automatic wait_out(input int idx, input logic [95:0] exp, input string nm);
    bit got;
    got = 0;
    tvalid = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = o_tvalid[idx];
    end
    if (!got) fail_timeout(nm);
    else chk(o_tdata[idx], exp, nm);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         idx;
    logic [7:0] x;
    logic [7:0] exp;
    string      nm;
  } vec_t;

  vec_t vt [11];

  initial begin
    logic [95:0] d;

    vt[0]  = '{0, 8'd0,   8'd0,   "pass_x0"};
    vt[1]  = '{0, 8'd255, 8'd255, "pass_x255"};
    vt[2]  = '{0, 8'd77,  8'd77,  "pass_x77"};
    vt[3]  = '{1, 8'd255, 8'd255, "c511_x255"};
    vt[4]  = '{1, 8'd0,   8'd0,   "c511_x0"};
    vt[5]  = '{1, 8'd128, 8'd128, "c511_x128"};
    vt[6]  = '{2, 8'd127, 8'd127, "c64_x127_floor"};
    vt[7]  = '{3, 8'd200, 8'd0,   "bm256_x200"};
    vt[8]  = '{4, 8'd10,  8'd255, "b255_x10"};
    vt[9]  = '{5, 8'd0,   8'd100, "c0_bm28_x0"};
    vt[10] = '{5, 8'd255, 8'd100, "c0_bm28_x255"};

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NCFG; g++) begin
      chk(o_tdata[g], 96'd0, "reset_tdata");
      chk({93'd0, o_tvalid[g], o_tuser[g], o_tlast[g]}, 96'd0, "reset_flags");
      chk({95'd0, i_tready[g]}, 96'd1, "reset_tready");
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ramp: every channel value 0..255 appears once at unity gain
    for (int k = 0; k < 64; k++) begin
      d = '0;
      for (int i = 0; i < 12; i++) d[8*i +: 8] = 8'(4 * k + i / 3);
      send(d, k == 0, (k % 16) == 15);
    end
    drain();

    for (int v = 0; v < 11; v++) begin
      d = {12{vt[v].x}};
      send(d, 1'b1, 1'b1);
      wait_out(vt[v].idx, {12{vt[v].exp}}, vt[v].nm);
      drain();
    end

    // 64-beat stream with a 5-cycle downstream stall in the middle
    bp_mode = 2;
    stall_from = tcyc + 20;
    tready_low = 0;
    for (int k = 0; k < 64; k++) send({$urandom, $urandom, $urandom}, k == 0, (k % 16) == 15);
    drain();
    chk(96'(tready_low), 96'd5, "stall_tready_low_cycles");
    bp_mode = 0;
    idle(2);

    // reset with three beats in flight
    for (int k = 0; k < 3; k++) send({$urandom, $urandom, $urandom}, k == 0, 1'b0);
    tvalid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    for (int g = 0; g < NCFG; g++) begin
      chk({95'd0, o_tvalid[g]}, 96'd0, "async_reset_valid");
      chk(o_tdata[g], 96'd0, "async_reset_tdata");
    end
    sb.delete();
    eff_c0 = int'(C_TAB[0]);
    eff_b0 = int'(B_TAB[0]);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk({95'd0, o_tvalid[0]}, 96'd0, "no_stale_after_reset");
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) send({$urandom, $urandom, $urandom}, k == 0, k == 7);
    drain();

    // random traffic with random gaps and random backpressure
    bp_mode = 1;
    for (int k = 0; k < 300; k++) begin
      send({$urandom, $urandom, $urandom}, (k % 16) == 0, (k % 8) == 7);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();
    bp_mode = 0;
    idle(2);

`ifdef BRIGHTNESS_CONTRAST_RUNTIME_CFG_EN
    cfg_c[0] = 9'd128;
    cfg_b[0] = 9'sd0;
    send({12{8'd160}}, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) send({12{8'd160}}, 1'b0, 1'b0);
    cfg_c[0] = 9'd256;
    for (int k = 0; k < 4; k++) send({12{8'd160}}, 1'b0, k == 3);
    wait_out(0, {12{8'd160}}, "frame1_keeps_c128");
    drain();
    send({12{8'd160}}, 1'b1, 1'b0);
    wait_out(0, {12{8'd192}}, "frame2_sof_c256");
    send({12{8'd160}}, 1'b0, 1'b1);
    wait_out(0, {12{8'd192}}, "frame2_body_c256");
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
